fifo_burst_reader: RTL and testbench

- Consumer side of the team's synchronous FIFO. On `start`, pops exactly `burst_len` words from the FIFO read port and presents them on a valid/ready output stream, marking the last word.
- Drives `fifo_rd_en` and observes `fifo_empty`. Accounts for the FIFO's registered read data, which arrives one cycle after `rd_en`.
- Sits between a FIFO instance and a downstream stream consumer.

---
 rtl/fifo_burst_reader_if.sv | 25 ++
 rtl/fifo_burst_reader.sv | 90 +++++++++
 tb/tb_fifo_burst_reader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: control, FIFO read port and output stream of the burst reader
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
);
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             busy;
  logic             done;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  modport master (
    input  start, burst_len, fifo_data, fifo_empty, m_ready,
    output busy, done, fifo_rd_en, m_data, m_valid, m_last
  );
  modport slave (
    output start, burst_len, fifo_data, fifo_empty, m_ready,
    input  busy, done, fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of words from a registered-output FIFO onto a valid/ready stream
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  fifo_burst_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] req_left_q, req_left_d;
  logic [LEN_W-1:0] out_left_q, out_left_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic             inflight_q;
  logic             done_q, done_d;
  logic             m_valid, pop, rd_en;
  logic [2:0]       credit;
  // A read is allowed only if the word it returns is guaranteed a buffer slot
  assign m_valid = buf_cnt_q != 2'd0;
  assign pop     = m_valid & bus.m_ready;
  assign credit  = {1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_en   = (state_q == RUN) & !bus.fifo_empty & (req_left_q != '0) & (credit < 3'd2);
  assign bus.fifo_rd_en = rd_en;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = done_q;
  assign bus.m_valid    = m_valid;
  assign bus.m_data     = m_valid ? buf_q[0] : '0;
  assign bus.m_last     = m_valid & (out_left_q == LEN_W'(1));
  // Burst control: latch length, count issued reads, finish on the final handshake
  always_comb begin
    state_d    = state_q;
    req_left_d = req_left_q;
    out_left_d = pop ? out_left_q - 1'b1 : out_left_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        req_left_d = bus.burst_len;
        out_left_d = bus.burst_len;
        state_d    = (bus.burst_len == '0) ? IDLE : RUN;
        done_d     = bus.burst_len == '0;
      end
      RUN: if (rd_en) begin
        req_left_d = req_left_q - 1'b1;
        state_d    = (req_left_q == LEN_W'(1)) ? DRAIN : RUN;
      end
      DRAIN: if (pop && out_left_q == LEN_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Two-entry buffer: head shifts out on pop, returning FIFO word lands at the new tail
  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 1'b1;
    end
    if (inflight_q) begin
      buf_d[buf_cnt_d[0]] = bus.fifo_data;
      buf_cnt_d           = buf_cnt_d + 1'b1;
    end
  end
  // State registers; reset abandons any burst and drops the word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_left_q <= '0;
      out_left_q <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      out_left_q <= out_left_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= rd_en;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed vectors and burst sequences against a behavioural FIFO
module tb_fifo_burst_reader;
  localparam int W = 8;
  localparam int L = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_burst_reader_if #(.WIDTH(W), .LEN_W(L)) bus();
  fifo_burst_reader #(.WIDTH(W), .LEN_W(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [0:255];
  int wp = 0;
  int rp = 0;
  logic flush = 1'b0;
  assign bus.fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (bus.fifo_rd_en && wp != rp) begin
      bus.fifo_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end
  task automatic push(input logic [7:0] d);
    mem[wp[7:0]] = d;
    wp++;
  endtask

  int checks = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.busy, bus.done, bus.fifo_rd_en, bus.m_valid, bus.m_data, bus.m_last};
  endfunction
  function automatic logic [12:0] mk(input int b, input int d, input int r, input int v, input int data, input int l);
    return {b[0], d[0], r[0], v[0], data[7:0], l[0]};
  endfunction

  logic [7:0] got[$];
  int last_idx, rd_err, cr_err, hold_err, vld_cnt, done_cnt, outst;
  logic end_seen, fin, prev_hold, hl, s_busy;
  logic [7:0] hd;
  task automatic clear();
    got.delete();
    last_idx = -1; rd_err = 0; cr_err = 0; hold_err = 0; vld_cnt = 0; done_cnt = 0; outst = 0;
    end_seen = 1'b0; prev_hold = 1'b0;
  endtask

  task automatic step(input logic rdy, input logic st, input logic [4:0] ln);
    logic pop;
    bus.m_ready = rdy; bus.start = st; bus.burst_len = ln;
    #1;
    pop = bus.m_valid && bus.m_ready;
    if (bus.fifo_rd_en && bus.fifo_empty) rd_err++;
    if (bus.fifo_rd_en && (outst - int'(pop) >= 2)) cr_err++;
    if (prev_hold && (!bus.m_valid || bus.m_data !== hd || bus.m_last !== hl)) hold_err++;
    prev_hold = bus.m_valid && !bus.m_ready;
    hd = bus.m_data; hl = bus.m_last; s_busy = bus.busy;
    if (bus.m_valid) vld_cnt++;
    if (pop) begin
      got.push_back(bus.m_data);
      if (bus.m_last) begin
        last_idx = got.size() - 1;
        end_seen = 1'b1;
      end
    end
    if (bus.done) done_cnt++;
    outst += int'(bus.fifo_rd_en) - int'(pop);
    @(negedge clk);
  endtask

  task automatic run(input int mode, input int push_at, input logic [7:0] push_base, input int ign_at, input int max);
    for (int i = 0; i < max && !end_seen; i++) begin
      if (i == push_at) for (int k = 0; k < 3; k++) push(push_base + 8'(k));
      step(mode == 0 ? 1'b1 : (i % 4 == 0 || i % 4 == 3), i == ign_at, i == ign_at ? 5'd7 : 5'd0);
    end
    fin = end_seen;
  endtask

  task automatic done_step(input string nm, input logic st, input logic [4:0] ln);
    int d0 = done_cnt;
    step(1'b1, st, ln);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_busy"}, s_busy, 0);
  endtask

  task automatic check_burst(input string nm, input int n, input logic [7:0] base);
    chk({nm, "_fin"}, fin, 1);
    chk({nm, "_count"}, got.size(), n);
    for (int k = 0; k < n; k++) chk($sformatf("%s_word%0d", nm, k), got[k], base + 8'(k));
    chk({nm, "_last_pos"}, last_idx, n - 1);
    chk({nm, "_rd_when_empty"}, rd_err, 0);
    chk({nm, "_credit"}, cr_err, 0);
    chk({nm, "_hold"}, hold_err, 0);
  endtask

  typedef struct packed {
    logic        st;
    logic [4:0]  ln;
    logic        rdy;
    logic [12:0] exp;
  } vec_t;
  vec_t v [11];

  initial begin
    v[0]  = '{1'b1, 5'd3, 1'b1, mk(0, 0, 0, 0, 'h00, 0)};
    v[1]  = '{1'b0, 5'd0, 1'b1, mk(1, 0, 1, 0, 'h00, 0)};
    v[2]  = '{1'b0, 5'd0, 1'b1, mk(1, 0, 1, 0, 'h00, 0)};
    v[3]  = '{1'b0, 5'd0, 1'b1, mk(1, 0, 1, 1, 'h11, 0)};
    v[4]  = '{1'b0, 5'd0, 1'b1, mk(1, 0, 0, 1, 'h22, 0)};
    v[5]  = '{1'b0, 5'd0, 1'b1, mk(1, 0, 0, 1, 'h33, 1)};
    v[6]  = '{1'b0, 5'd0, 1'b1, mk(0, 1, 0, 0, 'h00, 0)};
    v[7]  = '{1'b1, 5'd0, 1'b1, mk(0, 0, 0, 0, 'h00, 0)};
    v[8]  = '{1'b0, 5'd0, 1'b1, mk(0, 1, 0, 0, 'h00, 0)};
    v[9]  = '{1'b0, 5'd0, 1'b1, mk(0, 0, 0, 0, 'h00, 0)};
    v[10] = '{1'b0, 5'd0, 1'b1, mk(0, 0, 0, 0, 'h00, 0)};
    bus.start = 1'b0; bus.burst_len = 5'd0; bus.m_ready = 1'b0;
    clear();
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      bus.start = v[i].st; bus.burst_len = v[i].ln; bus.m_ready = v[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), outs(), v[i].exp);
      @(negedge clk);
    end
    chk("len0_fifo_untouched", wp - rp, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    clear();
    for (int k = 0; k < 4; k++) push(8'ha1 + 8'(k));
    step(1'b1, 1'b1, 5'd4);
    run(1, -1, 8'h00, -1, 60);
    check_burst("t2", 4, 8'ha1);
    done_step("t2", 1'b0, 5'd0);

    clear();
    push(8'hb1); push(8'hb2);
    step(1'b1, 1'b1, 5'd5);
    run(0, 10, 8'hb3, -1, 60);
    check_burst("t3", 5, 8'hb1);
    done_step("t3", 1'b0, 5'd0);

    clear();
    for (int k = 0; k < 3; k++) push(8'hc1 + 8'(k));
    for (int k = 0; k < 2; k++) push(8'hd1 + 8'(k));
    step(1'b1, 1'b1, 5'd3);
    run(0, -1, 8'h00, 2, 60);
    check_burst("t5a", 3, 8'hc1);
    done_step("t5a", 1'b1, 5'd2);
    clear();
    run(0, -1, 8'h00, -1, 60);
    check_burst("t5b", 2, 8'hd1);
    done_step("t5b", 1'b0, 5'd0);

    clear();
    for (int k = 0; k < 6; k++) push(8'he1 + 8'(k));
    step(1'b1, 1'b1, 5'd6);
    for (int i = 0; i < 20 && got.size() < 2; i++) step(1'b1, 1'b0, 5'd0);
    chk("t6_two_words", got.size(), 2);
    chk("t6_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", outs(), 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    clear();
    repeat (5) step(1'b1, 1'b0, 5'd0);
    chk("t6_no_spurious_valid", vld_cnt, 0);
    chk("t6_idle_after_reset", s_busy, 0);
    push(8'h5a);
    step(1'b1, 1'b1, 5'd1);
    run(0, -1, 8'h00, -1, 20);
    check_burst("t6", 1, 8'h5a);
    done_step("t6", 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
    $fatal(1);
  end
endmodule
